// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register-file sizing and architectural register indices
// Purpose: default address width / register count for the ARM register file,
//          plus the architectural indices of PC and LR.
// Ports:   none (package).
package reg_file_pkg;

    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_REGS = 16;

    localparam int RF_PC_IDX = 15;
    localparam int RF_LR_IDX = 14;

    typedef struct packed {
        logic valid;
        logic error;
    } wb_status_t;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational enable+address to one-hot decoder with range check
// Purpose: turns an enabled register address into a one-hot vector and flags
//          addresses outside the implemented register range.
// Ports:   en_i (enable), addr_i (address), onehot_o (one-hot, zero when disabled
//          or out of range), out_of_range_o (enabled and address >= NUM_REGS).
module onehot_decoder #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic              out_of_range_o
);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable and the compare
    // stays unsigned without truncating into the legal range.
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] LIMIT = AW1'(NUM_REGS);

    logic [ADDR_W:0] addr_ext;
    assign addr_ext = {1'b0, addr_i};

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = en_i && (addr_ext == AW1'(i));
        end
    end

    assign out_of_range_o = en_i && (addr_ext >= LIMIT);

endmodule

// File: rtl/reg_write_decoder_sb.sv
// rtl/reg_write_decoder_sb.sv - write-port decoder with pending-write scoreboard
// Purpose: decodes writeback address to a one-hot write enable (registered when
//          PIPE=1), tracks issued-but-not-written destinations, reports RAW
//          hazards on two source ports and stalls WAW / illegal issues.
// Ports:   clk, reset (sync, active-high);
//          issue_valid/issue_addr -> issue_stall;
//          wb_valid/wb_addr -> we_onehot, addr_err;
//          flush (drop all reservations);
//          src_a_addr/src_b_addr -> hazard_a/hazard_b;
//          pending (scoreboard state).
module reg_write_decoder_sb
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int PIPE     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic                issue_stall,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] we_onehot,
    output logic                addr_err,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   src_a_addr,
    input  logic [ADDR_W-1:0]   src_b_addr,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic [NUM_REGS-1:0] wb_oh, iss_oh, src_a_oh, src_b_oh;
    logic                wb_oor, iss_oor, src_a_oor, src_b_oor;
    logic                issue_accept;

    onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_wb (
        .en_i(wb_valid), .addr_i(wb_addr), .onehot_o(wb_oh), .out_of_range_o(wb_oor)
    );

    onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_issue (
        .en_i(issue_valid), .addr_i(issue_addr), .onehot_o(iss_oh), .out_of_range_o(iss_oor)
    );

    onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_src_a (
        .en_i(1'b1), .addr_i(src_a_addr), .onehot_o(src_a_oh), .out_of_range_o(src_a_oor)
    );

    onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_src_b (
        .en_i(1'b1), .addr_i(src_b_addr), .onehot_o(src_b_oh), .out_of_range_o(src_b_oor)
    );

    // Stall looks only at registered state: a same-cycle writeback does not
    // free the register for an issue in that same cycle.
    assign issue_stall  = issue_valid && (iss_oor || (|(iss_oh & pending_q)));
    assign issue_accept = issue_valid && !issue_stall && !flush;

    // A new reservation wins over a same-cycle writeback of that register
    // (that writeback belongs to an older, unreserved producer).
    always_comb begin
        pending_d = (pending_q & ~wb_oh) | (issue_accept ? iss_oh : '0);
        if (flush) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending  = pending_q;
    assign hazard_a = !src_a_oor && (|(pending_q & src_a_oh));
    assign hazard_b = !src_b_oor && (|(pending_q & src_b_oh));

    generate
        if (PIPE != 0) begin : g_pipe
            logic [NUM_REGS-1:0] we_q;
            logic                err_q;

            // Reset also squashes a writeback presented in the reset cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    we_q  <= '0;
                    err_q <= 1'b0;
                end else begin
                    we_q  <= wb_oh;
                    err_q <= wb_oor;
                end
            end

            assign we_onehot = we_q;
            assign addr_err  = err_q;
        end else begin : g_comb
            assign we_onehot = wb_oh;
            assign addr_err  = wb_oor;
        end
    endgenerate

endmodule

// File: tb/tb_reg_write_decoder_sb.sv
// tb/tb_reg_write_decoder_sb.sv - self-checking bench for reg_write_decoder_sb
module tb_reg_write_decoder_sb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: defaults (16 regs, PIPE=1)
    logic        a_issue_valid, a_wb_valid, a_flush;
    logic [3:0]  a_issue_addr, a_wb_addr, a_src_a, a_src_b;
    logic        a_issue_stall, a_err, a_haz_a, a_haz_b;
    logic [15:0] a_we, a_pending;

    // DUT B: 12 regs, PIPE=0
    logic        b_issue_valid, b_wb_valid, b_flush;
    logic [3:0]  b_issue_addr, b_wb_addr, b_src_a, b_src_b;
    logic        b_issue_stall, b_err, b_haz_a, b_haz_b;
    logic [11:0] b_we, b_pending;

    reg_write_decoder_sb dut_a (
        .clk(clk), .reset(reset),
        .issue_valid(a_issue_valid), .issue_addr(a_issue_addr), .issue_stall(a_issue_stall),
        .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .we_onehot(a_we), .addr_err(a_err),
        .flush(a_flush), .src_a_addr(a_src_a), .src_b_addr(a_src_b),
        .hazard_a(a_haz_a), .hazard_b(a_haz_b), .pending(a_pending)
    );

    reg_write_decoder_sb #(.ADDR_W(4), .NUM_REGS(12), .PIPE(0)) dut_b (
        .clk(clk), .reset(reset),
        .issue_valid(b_issue_valid), .issue_addr(b_issue_addr), .issue_stall(b_issue_stall),
        .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .we_onehot(b_we), .addr_err(b_err),
        .flush(b_flush), .src_a_addr(b_src_a), .src_b_addr(b_src_b),
        .hazard_a(b_haz_a), .hazard_b(b_haz_b), .pending(b_pending)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] we;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the write enable DUT A must show after this edge, then compare it.
    task automatic tick();
        exp_t e;
        exp_t got;
        e.we  = 16'h0;
        e.err = 1'b0;
        if (!reset && a_wb_valid) e.we = 16'h1 << a_wb_addr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk("we_onehot", {16'h0, a_we}, {16'h0, got.we});
            chk("addr_err", {31'h0, a_err}, {31'h0, got.err});
        end
    endtask

    initial begin
        reset = 1'b1;
        a_issue_valid = 1'b1; a_issue_addr = 4'd3;
        a_wb_valid = 1'b1;    a_wb_addr = 4'd5;
        a_flush = 1'b0;       a_src_a = 4'd3; a_src_b = 4'd5;
        b_issue_valid = 1'b1; b_issue_addr = 4'd2;
        b_wb_valid = 1'b0;    b_wb_addr = 4'd0;
        b_flush = 1'b0;       b_src_a = 4'd0; b_src_b = 4'd0;

        // Reset with all inputs active
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_pending", {16'h0, a_pending}, 32'h0);
            chk("reset_pending_b", {20'h0, b_pending}, 32'h0);
        end
        reset = 1'b0;
        a_issue_valid = 1'b0; a_wb_valid = 1'b0;
        b_issue_valid = 1'b0;
        tick();
        chk("post_reset_pending", {16'h0, a_pending}, 32'h0);

        // wb r5: we at N+1 only
        a_wb_valid = 1'b1; a_wb_addr = 4'd5;
        tick();
        chk("we_r5_value", {16'h0, a_we}, 32'h0020);
        a_wb_valid = 1'b0;
        tick();

        // issue r3, then WAW retry with RAW on src A
        a_issue_valid = 1'b1; a_issue_addr = 4'd3; a_src_a = 4'd3;
        #1;
        chk("issue_r3_accept", {31'h0, a_issue_stall}, 32'h0);
        chk("haz_a_before", {31'h0, a_haz_a}, 32'h0);
        tick();
        chk("pending_r3", {16'h0, a_pending}, 32'h0008);
        chk("issue_r3_waw", {31'h0, a_issue_stall}, 32'h1);
        chk("haz_a_r3", {31'h0, a_haz_a}, 32'h1);
        tick();
        chk("pending_r3_hold", {16'h0, a_pending}, 32'h0008);

        // wb r3 clears; retry accepted
        a_issue_valid = 1'b0; a_wb_valid = 1'b1; a_wb_addr = 4'd3;
        tick();
        chk("pending_r3_clr", {16'h0, a_pending}, 32'h0);
        a_wb_valid = 1'b0; a_issue_valid = 1'b1; a_issue_addr = 4'd3;
        #1;
        chk("retry_r3_accept", {31'h0, a_issue_stall}, 32'h0);
        tick();
        chk("pending_r3_again", {16'h0, a_pending}, 32'h0008);
        a_issue_valid = 1'b0; a_wb_valid = 1'b1; a_wb_addr = 4'd3;
        tick();
        a_wb_valid = 1'b0;

        // pending = {r2, r7}
        a_issue_valid = 1'b1; a_issue_addr = 4'd2;
        tick();
        a_issue_addr = 4'd7;
        tick();
        chk("pending_r2_r7", {16'h0, a_pending}, 32'h0084);
        a_wb_valid = 1'b1; a_wb_addr = 4'd7; a_src_b = 4'd2;
        #1;
        chk("same_addr_stall", {31'h0, a_issue_stall}, 32'h1);
        chk("haz_b_r2", {31'h0, a_haz_b}, 32'h1);
        tick();
        chk("pending_r2_only", {16'h0, a_pending}, 32'h0004);
        a_issue_valid = 1'b0; a_wb_addr = 4'd2;
        tick();
        a_wb_valid = 1'b0;
        chk("pending_empty", {16'h0, a_pending}, 32'h0);

        // Fill all, then flush + wb r0 + issue r1
        a_issue_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_issue_addr = 4'(i);
            tick();
        end
        chk("pending_full", {16'h0, a_pending}, 32'hFFFF);
        a_flush = 1'b1; a_wb_valid = 1'b1; a_wb_addr = 4'd0; a_issue_addr = 4'd1;
        #1;
        chk("flush_stall", {31'h0, a_issue_stall}, 32'h1);
        tick();
        chk("flush_pending", {16'h0, a_pending}, 32'h0);
        chk("flush_we_r0", {16'h0, a_we}, 32'h0001);
        a_flush = 1'b0; a_wb_valid = 1'b0; a_issue_valid = 1'b0;
        tick();

        // Reset in the same cycle as wb r9 squashes it
        a_wb_valid = 1'b1; a_wb_addr = 4'd9; reset = 1'b1;
        tick();
        chk("reset_wb_r9", {16'h0, a_we}, 32'h0);
        reset = 1'b0; a_wb_valid = 1'b0;
        tick();
        chk("after_reset_we", {16'h0, a_we}, 32'h0);

        // Reset the cycle after wb r9: write already visible, then gone
        a_wb_valid = 1'b1; a_wb_addr = 4'd9;
        tick();
        a_wb_valid = 1'b0; reset = 1'b1;
        tick();
        chk("reset_after_r9", {16'h0, a_we}, 32'h0);
        reset = 1'b0;
        tick();

        // DUT B: 12 registers, combinational decode
        b_wb_valid = 1'b1; b_wb_addr = 4'd13;
        #1;
        chk("b_we_illegal", {20'h0, b_we}, 32'h0);
        chk("b_err_illegal", {31'h0, b_err}, 32'h1);
        b_wb_addr = 4'd11;
        #1;
        chk("b_we_r11", {20'h0, b_we}, 32'h0800);
        chk("b_err_r11", {31'h0, b_err}, 32'h0);
        b_wb_valid = 1'b0;
        b_issue_valid = 1'b1; b_issue_addr = 4'd12;
        #1;
        chk("b_issue_illegal", {31'h0, b_issue_stall}, 32'h1);
        tick();
        chk("b_pending_unch", {20'h0, b_pending}, 32'h0);
        b_issue_addr = 4'd11;
        tick();
        chk("b_pending_r11", {20'h0, b_pending}, 32'h0800);
        b_issue_valid = 1'b0; b_src_a = 4'd11; b_src_b = 4'd15;
        #1;
        chk("b_haz_a_r11", {31'h0, b_haz_a}, 32'h1);
        chk("b_haz_b_illegal", {31'h0, b_haz_b}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
